// File: rtl/b10_tally_station.sv
// Station side of the b10 vote link: handshakes frames in, replies ACK/NACK, tallies votes into saturating counters.
// Optional wait-state watchdog is enabled by defining TALLY_TIMEOUT_EN.
module b10_tally_station #(
   parameter int       CNT_W     = 8,
   parameter logic [3:0] ACK_CODE  = 4'b0110,
   parameter logic [3:0] NACK_CODE = 4'b0000
`ifdef TALLY_TIMEOUT_EN
   ,
   parameter int       TIMEOUT   = 255
`endif
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic             start_i,
   input  logic             tally_clr_i,
   input  logic [3:0]       v_out_i,
   input  logic             cts_i,
   input  logic             ctr_i,
   output logic             rtr_o,
   output logic             rts_o,
   output logic [3:0]       v_in_o,
   output logic [CNT_W-1:0] green_cnt_o,
   output logic [CNT_W-1:0] red_cnt_o,
   output logic [CNT_W-1:0] blank_cnt_o,
   output logic [CNT_W-1:0] err_cnt_o,
   output logic             session_done_o,
   output logic             busy_o,
   output logic             timeout_err_o
);

   localparam logic [3:0] END_CODE = 4'b0110;

   typedef enum logic [2:0] {S_OFF, S_RDY, S_WCTR, S_WCTRL, S_WCTS, S_ENDW} state_e;

   state_e           state_q;
   logic             start_q;
   logic [3:0]       frm_q;
   logic [3:0]       reply_q;
   logic             pend_q;
   logic             nack_q;
   logic             start_fall;
   logic             adv;
   logic             frm_ok;
   logic             echo;
   logic [3:0]       reply_w;
   logic             inc_g, inc_r, inc_b, inc_e;
   logic [CNT_W-1:0] green_d, red_d, blank_d, err_d;

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] x);
      return (x == {CNT_W{1'b1}}) ? x : x + 1'b1;
   endfunction

   assign start_fall = start_q & ~start_i;
   assign busy_o     = (state_q != S_OFF);

   // Condition that lets the current state move on; used by the FSM and the watchdog.
   always_comb begin
      adv = 1'b0;
      case (state_q)
         S_OFF:   adv = start_fall;
         S_RDY:   adv = cts_i;
         S_WCTR:  adv = ctr_i;
         S_WCTRL: adv = ~ctr_i;
         S_WCTS:  adv = ~cts_i;
         S_ENDW:  adv = ~cts_i;
         default: adv = 1'b0;
      endcase
   end

   always_comb begin
      frm_ok  = (frm_q[3] == ^frm_q[2:0]);
      echo    = nack_q && (frm_q == NACK_CODE);
      inc_g   = 1'b0;
      inc_r   = 1'b0;
      inc_b   = 1'b0;
      inc_e   = 1'b0;
      reply_w = ACK_CODE;
      if (echo) begin
         reply_w = ACK_CODE;
      end else if (!frm_ok) begin
         inc_e   = 1'b1;
         reply_w = NACK_CODE;
      end else if (frm_q[0] & frm_q[1] & ~frm_q[2]) begin
         inc_g = 1'b1;
      end else if (frm_q[0] & frm_q[2] & ~frm_q[1]) begin
         inc_r = 1'b1;
      end else begin
         inc_b = 1'b1;
      end
   end

   always_comb begin
      green_d = green_cnt_o;
      red_d   = red_cnt_o;
      blank_d = blank_cnt_o;
      err_d   = err_cnt_o;
      if (tally_clr_i) begin
         green_d = '0;
         red_d   = '0;
         blank_d = '0;
         err_d   = '0;
      end else if (pend_q) begin
         if (inc_g) green_d = sat_inc(green_cnt_o);
         if (inc_r) red_d   = sat_inc(red_cnt_o);
         if (inc_b) blank_d = sat_inc(blank_cnt_o);
         if (inc_e) err_d   = sat_inc(err_cnt_o);
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         green_cnt_o <= '0;
         red_cnt_o   <= '0;
         blank_cnt_o <= '0;
         err_cnt_o   <= '0;
      end else begin
         green_cnt_o <= green_d;
         red_cnt_o   <= red_d;
         blank_cnt_o <= blank_d;
         err_cnt_o   <= err_d;
      end
   end

`ifdef TALLY_TIMEOUT_EN
   localparam int TW = $clog2(TIMEOUT + 1);
   logic [TW-1:0] tmo_q;
   logic          tmo_hit;
   assign tmo_hit = (state_q != S_OFF) && !adv && (tmo_q == TW'(TIMEOUT - 1));
`endif

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q        <= S_OFF;
         start_q        <= 1'b0;
         frm_q          <= '0;
         reply_q        <= '0;
         pend_q         <= 1'b0;
         nack_q         <= 1'b0;
         rtr_o          <= 1'b0;
         rts_o          <= 1'b0;
         v_in_o         <= '0;
         session_done_o <= 1'b0;
`ifdef TALLY_TIMEOUT_EN
         tmo_q          <= '0;
         timeout_err_o  <= 1'b0;
`endif
      end else begin
         start_q        <= start_i;
         session_done_o <= 1'b0;
         pend_q         <= 1'b0;
         // Classification lands one cycle after the frame is latched.
         if (pend_q) begin
            nack_q  <= ~echo & ~frm_ok;
            reply_q <= reply_w;
         end
         case (state_q)
            S_OFF: if (start_fall) begin
               state_q <= S_RDY;
               rtr_o   <= 1'b1;
               nack_q  <= 1'b0;
`ifdef TALLY_TIMEOUT_EN
               timeout_err_o <= 1'b0;
`endif
            end
            S_RDY: if (cts_i) begin
               frm_q <= v_out_i;
               if (v_out_i == END_CODE) begin
                  state_q <= S_ENDW;
                  rtr_o   <= 1'b0;
               end else begin
                  state_q <= S_WCTR;
                  pend_q  <= 1'b1;
               end
            end
            S_WCTR: if (ctr_i) begin
               v_in_o  <= pend_q ? reply_w : reply_q;
               rts_o   <= 1'b1;
               state_q <= S_WCTRL;
            end
            S_WCTRL: if (!ctr_i) begin
               rts_o   <= 1'b0;
               rtr_o   <= 1'b0;
               state_q <= S_WCTS;
            end
            S_WCTS: if (!cts_i) begin
               rtr_o   <= 1'b1;
               state_q <= S_RDY;
            end
            S_ENDW: if (!cts_i) begin
               session_done_o <= 1'b1;
               state_q        <= S_OFF;
            end
            default: state_q <= S_OFF;
         endcase
`ifdef TALLY_TIMEOUT_EN
         tmo_q <= (adv || state_q == S_OFF) ? '0 : tmo_q + 1'b1;
         if (tmo_hit) begin
            state_q       <= S_OFF;
            rtr_o         <= 1'b0;
            rts_o         <= 1'b0;
            timeout_err_o <= 1'b1;
            tmo_q         <= '0;
         end
`endif
      end
   end

`ifndef TALLY_TIMEOUT_EN
   assign timeout_err_o = 1'b0;
`endif

endmodule
